// File: rtl/corr_intr_gen_pkg.sv
// Shared definitions for the correlator interrupt generator:
// FSM state encoding, period-code width and the code-to-epoch-mask mapping.
package corr_intr_gen_pkg;

    localparam int INTR_CODE_W = 3;
    localparam int MASK_W      = 7;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_PENDING  = 2'd2
    } intr_state_e;

    // Code c selects a period of 2^(c-1) epochs; the mask is that period minus one.
    function automatic logic [MASK_W-1:0] period_mask(input logic [INTR_CODE_W-1:0] code);
        logic [MASK_W-1:0] m;
        if (code == '0) begin
            m = '0;
        end else begin
            m = (MASK_W'(1) << (code - INTR_CODE_W'(1))) - MASK_W'(1);
        end
        return m;
    endfunction

endpackage

// File: rtl/corr_intr_gen_rise_detect.sv
// Purpose: registered single-bit rising-edge detector.
// Latency: rise is high for one cycle, the cycle after the level is first sampled high.
// Backpressure: none; free-running, every edge is reported.
module corr_intr_gen_rise_detect (
    input  logic dclk,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/corr_intr_gen.sv
// Purpose: decimate the epoch strobe by 2^(c-1) and raise a level irq with overrun tracking.
// Latency: epoch -> irq/irq_pulse 1 cycle; ack or read-done level rise -> effect 2 cycles.
// Backpressure: none; events arriving while irq is pending are counted as overruns.
module corr_intr_gen
    import corr_intr_gen_pkg::*;
#(
    parameter int MISS_W = 8,
    parameter int CNT_W  = 6
) (
    input  logic              dclk,
    input  logic              reset_n,
    input  logic              epoch,
    input  logic [3:0]        intr_cntl_sync,
    input  logic              intr_cntl_rd_en_sync,
    output logic              irq,
    output logic              irq_pulse,
    output logic              overrun,
    output logic [MISS_W-1:0] miss_cnt,
    output logic              busy
);

    logic [INTR_CODE_W-1:0] code;
    logic [INTR_CODE_W-1:0] code_q;
    logic [CNT_W-1:0]       mask;
    logic [CNT_W-1:0]       ep_cnt;
    logic [CNT_W-1:0]       ep_cnt_nxt;
    logic                   code_chg;
    logic                   fire;
    logic                   ack;
    logic                   rd;
    logic                   ovr_evt;

    intr_state_e            state;
    intr_state_e            state_nxt;
    logic                   irq_nxt;
    logic                   irq_pulse_nxt;
    logic                   overrun_nxt;
    logic [MISS_W-1:0]      miss_cnt_nxt;

    assign code     = intr_cntl_sync[INTR_CODE_W-1:0];
    assign code_chg = (code != code_q);
    assign mask     = CNT_W'(period_mask(code));
    assign busy     = (state != ST_DISABLED);

    corr_intr_gen_rise_detect u_ack_edge (
        .dclk    (dclk),
        .reset_n (reset_n),
        .level   (intr_cntl_sync[3]),
        .rise    (ack)
    );

    corr_intr_gen_rise_detect u_rd_edge (
        .dclk    (dclk),
        .reset_n (reset_n),
        .level   (intr_cntl_rd_en_sync),
        .rise    (rd)
    );

    // A code change restarts the period from zero and drops the epoch of that cycle.
    always_comb begin
        ep_cnt_nxt = ep_cnt;
        fire       = 1'b0;
        if (code_chg || (state == ST_DISABLED)) begin
            ep_cnt_nxt = '0;
        end else if (epoch) begin
            if (ep_cnt == mask) begin
                ep_cnt_nxt = '0;
                fire       = 1'b1;
            end else begin
                ep_cnt_nxt = ep_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        irq_nxt       = irq;
        irq_pulse_nxt = 1'b0;
        overrun_nxt   = overrun;
        miss_cnt_nxt  = miss_cnt;
        ovr_evt       = 1'b0;

        if (code_chg) begin
            state_nxt = (code == '0) ? ST_DISABLED : ST_ARMED;
            irq_nxt   = 1'b0;
        end else begin
            case (state)
                ST_DISABLED: begin
                    irq_nxt = 1'b0;
                end
                ST_ARMED: begin
                    if (fire) begin
                        irq_nxt       = 1'b1;
                        irq_pulse_nxt = 1'b1;
                        state_nxt     = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    // A simultaneous ack is consumed by the new event, so it is not an overrun.
                    if (fire) begin
                        irq_pulse_nxt = 1'b1;
                        ovr_evt       = ~ack;
                    end else if (ack) begin
                        irq_nxt   = 1'b0;
                        state_nxt = ST_ARMED;
                    end
                end
                default: begin
                    irq_nxt   = 1'b0;
                    state_nxt = ST_DISABLED;
                end
            endcase
        end

        if (rd) begin
            overrun_nxt  = 1'b0;
            miss_cnt_nxt = '0;
        end
        if (ovr_evt) begin
            overrun_nxt = 1'b1;
            if (rd) begin
                miss_cnt_nxt = MISS_W'(1);
            end else if (miss_cnt != {MISS_W{1'b1}}) begin
                miss_cnt_nxt = miss_cnt + MISS_W'(1);
            end
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_DISABLED;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            code_q    <= '0;
            ep_cnt    <= '0;
            irq       <= 1'b0;
            irq_pulse <= 1'b0;
            overrun   <= 1'b0;
            miss_cnt  <= '0;
        end else begin
            code_q    <= code;
            ep_cnt    <= ep_cnt_nxt;
            irq       <= irq_nxt;
            irq_pulse <= irq_pulse_nxt;
            overrun   <= overrun_nxt;
            miss_cnt  <= miss_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_corr_intr_gen.sv
// Bench for corr_intr_gen: a vector table plus hand-built sequences for the multi-cycle cases.
// Expected outputs are queued as each cycle is driven and popped when the DUT output is sampled.
module tb_corr_intr_gen;

    logic       dclk;
    logic       reset_n;
    logic       epoch;
    logic [3:0] intr_cntl_sync;
    logic       intr_cntl_rd_en_sync;
    logic       irq;
    logic       irq_pulse;
    logic       overrun;
    logic [7:0] miss_cnt;
    logic       busy;

    typedef struct packed {
        logic       irq;
        logic       pulse;
        logic       ovr;
        logic [7:0] miss;
        logic       busy;
    } exp_t;

    typedef struct packed {
        logic [2:0] code;
        logic       ep;
        logic       ack;
        logic       rd;
        exp_t       x;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    corr_intr_gen #(.MISS_W(8), .CNT_W(6)) dut (
        .dclk                 (dclk),
        .reset_n              (reset_n),
        .epoch                (epoch),
        .intr_cntl_sync       (intr_cntl_sync),
        .intr_cntl_rd_en_sync (intr_cntl_rd_en_sync),
        .irq                  (irq),
        .irq_pulse            (irq_pulse),
        .overrun              (overrun),
        .miss_cnt             (miss_cnt),
        .busy                 (busy)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    function automatic exp_t mk(input int i, input int p, input int o, input int m, input int b);
        exp_t x;
        x.irq   = 1'(i);
        x.pulse = 1'(p);
        x.ovr   = 1'(o);
        x.miss  = 8'(m);
        x.busy  = 1'(b);
        return x;
    endfunction

    function automatic vec_t v(input int c, input int e, input int a, input int r,
                               input int i, input int p, input int o, input int m, input int b);
        vec_t t;
        t.code = 3'(c);
        t.ep   = 1'(e);
        t.ack  = 1'(a);
        t.rd   = 1'(r);
        t.x    = mk(i, p, o, m, b);
        return t;
    endfunction

    task automatic check_front(input string tag);
        exp_t x;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: no expected entry queued", tag);
        end else begin
            x = exp_q.pop_front();
            if (irq !== x.irq || irq_pulse !== x.pulse || overrun !== x.ovr ||
                miss_cnt !== x.miss || busy !== x.busy) begin
                n_err++;
                $display("FAIL %s: got irq=%0b pulse=%0b ovr=%0b miss=%0d busy=%0b, want irq=%0b pulse=%0b ovr=%0b miss=%0d busy=%0b",
                         tag, irq, irq_pulse, overrun, miss_cnt, busy,
                         x.irq, x.pulse, x.ovr, x.miss, x.busy);
            end
        end
    endtask

    task automatic apply(input string tag, input int c, input int e, input int a, input int r,
                         input exp_t x);
        intr_cntl_sync       = {1'(a), 3'(c)};
        epoch                = 1'(e);
        intr_cntl_rd_en_sync = 1'(r);
        exp_q.push_back(x);
        @(posedge dclk);
        #1;
        check_front(tag);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then releases with code c held.
    task automatic do_reset(input string tag, input int c);
        intr_cntl_sync       = {1'b0, 3'(c)};
        epoch                = 1'b0;
        intr_cntl_rd_en_sync = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        check_front(tag);
        repeat (2) @(posedge dclk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n              = 1'b1;
        epoch                = 1'b0;
        intr_cntl_sync       = 4'd0;
        intr_cntl_rd_en_sync = 1'b0;

        // Disabled after reset: epochs have no effect.
        do_reset("t1_reset", 0);
        for (int k = 0; k < 10; k++)
            apply($sformatf("t1_ep%0d", k), 0, 1, 0, 0, mk(0, 0, 0, 0, 0));

        //          c  e  a  r  irq pls ovr miss busy
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(2, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(2, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(2, 1, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(v(2, 0, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(2, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(2, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(2, 1, 1, 0, 1, 1, 0, 0, 1));
        tbl.push_back(v(2, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(2, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(2, 1, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(v(2, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(2, 1, 0, 0, 1, 1, 1, 1, 1));
        tbl.push_back(v(2, 1, 0, 0, 1, 0, 1, 1, 1));
        tbl.push_back(v(2, 1, 0, 0, 1, 1, 1, 2, 1));
        tbl.push_back(v(2, 0, 0, 1, 1, 0, 1, 2, 1));
        tbl.push_back(v(2, 0, 0, 1, 1, 0, 0, 0, 1));
        tbl.push_back(v(2, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(2, 1, 1, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(2, 1, 1, 0, 1, 1, 0, 0, 1));
        tbl.push_back(v(2, 0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 1, 1, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 0, 1, 1, 1, 1, 1));
        tbl.push_back(v(1, 1, 0, 1, 1, 1, 1, 2, 1));
        tbl.push_back(v(1, 1, 0, 1, 1, 1, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 1, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0));

        do_reset("tbl_reset", 0);
        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("tbl[%0d]", i), int'(tbl[i].code), int'(tbl[i].ep),
                  int'(tbl[i].ack), int'(tbl[i].rd), tbl[i].x);

        // P=4, an epoch every 5 cycles, ack raised 2 cycles after each irq.
        do_reset("t2_reset", 0);
        apply("t2_code", 3, 0, 0, 0, mk(0, 0, 0, 0, 1));
        for (int n = 1; n <= 12; n++) begin
            for (int j = 0; j < 5; j++) begin
                bit hit;
                hit = (n % 4 == 0);
                apply($sformatf("t2_n%0d_j%0d", n, j), 3, (j == 0), (hit && j == 2), 0,
                      mk(hit && j <= 2, hit && j == 0, 0, 0, 1));
            end
        end

        // P=1, three unacked epochs, then read-done clears overrun status only.
        do_reset("t3_reset", 0);
        apply("t3_code", 1, 0, 0, 0, mk(0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++)
            apply($sformatf("t3_ep%0d", k), 1, 1, 0, 0, mk(1, 1, k > 0, k, 1));
        apply("t3_rd0", 1, 0, 0, 1, mk(1, 0, 1, 2, 1));
        apply("t3_rd1", 1, 0, 0, 1, mk(1, 0, 0, 0, 1));
        apply("t3_idle", 1, 0, 0, 0, mk(1, 0, 0, 0, 1));

        // Saturation of the miss counter, then fire+ack leaves it unchanged.
        do_reset("t4_reset", 0);
        apply("t4_code", 1, 0, 0, 0, mk(0, 0, 0, 0, 1));
        for (int k = 0; k < 300; k++)
            apply($sformatf("t4_ep%0d", k), 1, 1, 0, 0,
                  mk(1, 1, k > 0, (k > 255) ? 255 : k, 1));
        apply("t4_rd0", 1, 0, 0, 1, mk(1, 0, 1, 255, 1));
        apply("t4_rd1", 1, 0, 0, 1, mk(1, 0, 0, 0, 1));
        apply("t4_ovr", 1, 1, 1, 0, mk(1, 1, 1, 1, 1));
        apply("t4_fire_ack", 1, 1, 1, 0, mk(1, 1, 1, 1, 1));
        apply("t4_idle", 1, 0, 0, 0, mk(1, 0, 1, 1, 1));

        // P=64 raises irq, then a code change clears it and restarts the count.
        do_reset("t5_reset", 0);
        apply("t5_code", 7, 0, 0, 0, mk(0, 0, 0, 0, 1));
        for (int k = 0; k < 94; k++)
            apply($sformatf("t5_ep%0d", k), 7, 1, 0, 0, mk(k >= 63, k == 63, 0, 0, 1));
        apply("t5_chg", 2, 1, 0, 0, mk(0, 0, 0, 0, 1));
        apply("t5_ep_a", 2, 1, 0, 0, mk(0, 0, 0, 0, 1));
        apply("t5_ep_b", 2, 1, 0, 0, mk(1, 1, 0, 0, 1));
        apply("t6_mid", 2, 1, 0, 0, mk(1, 0, 0, 0, 1));

        // Reset while irq is high, release with c=2 held.
        do_reset("t6_reset", 2);
        apply("t6_rel", 2, 0, 0, 0, mk(0, 0, 0, 0, 1));
        apply("t6_ep_a", 2, 1, 0, 0, mk(0, 0, 0, 0, 1));
        apply("t6_ep_b", 2, 1, 0, 0, mk(1, 1, 0, 0, 1));

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
